cpu_debug_master: RTL and testbench

//  Debug-port initiator for the pipelined CPU. Parses byte-stream command frames from a host link (UART RX side).

---
 rtl/cpu_debug_master_if.sv | 22 ++
 rtl/cpu_debug_master.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_debug_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_debug_master_if.sv
// Host byte-stream link between the UART wrapper and the CPU debug master.
// The master modport is the host side; the slave modport is the debug master.
interface cpu_debug_master_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // A byte moves on a channel only in a cycle where valid and ready are both high.
    // The sender holds data and valid steady until that cycle. Ready may change at any time.
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/cpu_debug_master.sv
// Debug-port initiator: parses host command frames, drives the CPU inst/data/rf
// debug ports and CPU reset, and returns read data or status bytes to the host.
module cpu_debug_master #(
    parameter logic [7:0] ACK_BYTE      = 8'hA5,
    parameter logic [7:0] ERR_OPC       = 8'hEE,
    parameter logic [7:0] ERR_RUN       = 8'hEB,
    parameter bit         HOLD_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_debug_master_if.slave    link,
    output logic                 cpu_rstn,
    output logic                 inst_we,
    output logic                 data_we,
    output logic                 rf_dcp_we,
    output logic                 rf_dcp_rd,
    output logic [7:0]           inst_addr,
    output logic [7:0]           data_addr,
    output logic [4:0]           rf_addr,
    output logic [31:0]          inst_in,
    output logic [31:0]          data_in,
    output logic [31:0]          rf_in,
    input  logic [31:0]          inst_out,
    input  logic [31:0]          data_out,
    input  logic [31:0]          rf_out,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_EXEC   = 3'd3,
        S_SAMPLE = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q;       // 1 inst, 2 data, 3 rf
    logic        is_rd_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q;
    logic [1:0]  last_q;
    logic [31:0] rbuf_q;
    logic        cpu_rstn_q;
    logic        rx_ready_c;
    logic        tx_valid_c;
    logic        rx_fire;
    logic        tx_fire;
    logic        go;
    logic [31:0] sel_out;

    // Memory/rf opcodes are 0x01..0x03 (write) and 0x11..0x13 (read).
    function automatic logic is_mem(input logic [7:0] b);
        return (b[7:5] == 3'b000) && (b[3:2] == 2'b00) && (b[1:0] != 2'b00);
    endfunction

    assign rx_fire       = link.rx_valid & rx_ready_c;
    assign tx_fire       = tx_valid_c & link.tx_ready;
    assign go            = ~cpu_rstn_q;
    assign link.rx_ready = rx_ready_c;
    assign link.tx_valid = tx_valid_c;
    assign link.tx_data  = (state_q == S_RESP) ? rbuf_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign cpu_rstn      = cpu_rstn_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;

    always_comb begin
        sel_out = 32'h0;
        case (sel_q)
            2'd1:    sel_out = inst_out;
            2'd2:    sel_out = data_out;
            2'd3:    sel_out = rf_out;
            default: sel_out = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        rx_ready_c = 1'b0;
        tx_valid_c = 1'b0;
        inst_we    = 1'b0;
        data_we    = 1'b0;
        rf_dcp_we  = 1'b0;
        rf_dcp_rd  = 1'b0;
        case (state_q)
            S_IDLE: begin
                rx_ready_c = 1'b1;
                if (link.rx_valid) state_d = is_mem(link.rx_data) ? S_ADDR : S_RESP;
            end
            S_ADDR: begin
                rx_ready_c = 1'b1;
                if (link.rx_valid) state_d = is_rd_q ? S_EXEC : S_DATA;
            end
            S_DATA: begin
                rx_ready_c = 1'b1;
                if (link.rx_valid && cnt_q == 2'd3) state_d = S_EXEC;
            end
            S_EXEC: begin
                inst_we   = go & ~is_rd_q & (sel_q == 2'd1);
                data_we   = go & ~is_rd_q & (sel_q == 2'd2);
                rf_dcp_we = go & ~is_rd_q & (sel_q == 2'd3);
                rf_dcp_rd = go &  is_rd_q & (sel_q == 2'd3);
                state_d   = S_SAMPLE;
            end
            S_SAMPLE: begin
                rf_dcp_rd = go & is_rd_q & (sel_q == 2'd3);
                state_d   = S_RESP;
            end
            S_RESP: begin
                tx_valid_c = 1'b1;
                if (link.tx_ready && cnt_q == last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= 2'd0;
            is_rd_q    <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 32'h0;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            rbuf_q     <= 32'h0;
            cpu_rstn_q <= ~HOLD_ON_RESET;
            inst_addr  <= 8'h00;
            data_addr  <= 8'h00;
            rf_addr    <= 5'd0;
            inst_in    <= 32'h0;
            data_in    <= 32'h0;
            rf_in      <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: if (rx_fire) begin
                    sel_q   <= link.rx_data[1:0];
                    is_rd_q <= link.rx_data[4];
                    cnt_q   <= 2'd0;
                    last_q  <= 2'd0;
                    if (link.rx_data == 8'h20) begin
                        rbuf_q     <= {24'h0, ACK_BYTE};
                        cpu_rstn_q <= 1'b0;
                    end else if (link.rx_data == 8'h21) begin
                        rbuf_q     <= {24'h0, ACK_BYTE};
                        cpu_rstn_q <= 1'b1;
                    end else if (!is_mem(link.rx_data)) begin
                        rbuf_q <= {24'h0, ERR_OPC};
                    end
                end
                S_ADDR: if (rx_fire) begin
                    addr_q <= link.rx_data;
                    cnt_q  <= 2'd0;
                    // Reads go straight to EXEC, so the port address is loaded here.
                    if (is_rd_q && go) begin
                        case (sel_q)
                            2'd1:    inst_addr <= link.rx_data;
                            2'd2:    data_addr <= link.rx_data;
                            2'd3:    rf_addr   <= link.rx_data[4:0];
                            default: ;
                        endcase
                    end
                end
                S_DATA: if (rx_fire) begin
                    wdata_q[{cnt_q, 3'b000} +: 8] <= link.rx_data;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3 && go) begin
                        case (sel_q)
                            2'd1: begin
                                inst_addr <= addr_q;
                                inst_in   <= {link.rx_data, wdata_q[23:0]};
                            end
                            2'd2: begin
                                data_addr <= addr_q;
                                data_in   <= {link.rx_data, wdata_q[23:0]};
                            end
                            2'd3: begin
                                rf_addr <= addr_q[4:0];
                                rf_in   <= {link.rx_data, wdata_q[23:0]};
                            end
                            default: ;
                        endcase
                    end
                end
                S_SAMPLE: begin
                    cnt_q <= 2'd0;
                    if (go && is_rd_q) begin
                        rbuf_q <= sel_out;
                        last_q <= 2'd3;
                    end else begin
                        rbuf_q <= {24'h0, go ? ACK_BYTE : ERR_RUN};
                        last_q <= 2'd0;
                    end
                end
                S_RESP: if (tx_fire) begin
                    cnt_q <= (cnt_q == last_q) ? 2'd0 : cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_master.sv
// Directed bench for cpu_debug_master: host-side driver, small CPU memory model,
// and a queue-based scoreboard of expected TX bytes.
module tb_cpu_debug_master;

    logic        clk;
    logic        rst;
    logic        cpu_rstn;
    logic        inst_we, data_we, rf_dcp_we, rf_dcp_rd;
    logic [7:0]  inst_addr, data_addr;
    logic [4:0]  rf_addr;
    logic [31:0] inst_in, data_in, rf_in;
    logic [31:0] inst_out, data_out, rf_out;
    logic        busy;
    logic [2:0]  dbg_state;

    cpu_debug_master_if link ();

    cpu_debug_master dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .cpu_rstn  (cpu_rstn),
        .inst_we   (inst_we),
        .data_we   (data_we),
        .rf_dcp_we (rf_dcp_we),
        .rf_dcp_rd (rf_dcp_rd),
        .inst_addr (inst_addr),
        .data_addr (data_addr),
        .rf_addr   (rf_addr),
        .inst_in   (inst_in),
        .data_in   (data_in),
        .rf_in     (rf_in),
        .inst_out  (inst_out),
        .data_out  (data_out),
        .rf_out    (rf_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- CPU model and monitors ----------------
    logic [31:0] inst_mem [256];
    logic [31:0] data_mem [256];
    logic [31:0] rf_mem   [32];

    assign inst_out = inst_mem[inst_addr];
    assign data_out = data_mem[data_addr];
    assign rf_out   = rf_dcp_rd ? rf_mem[rf_addr] : 32'hBAD0_BAD0;

    logic [7:0]  got_q[$];
    int          inst_we_n, data_we_n, rf_we_n, rf_rd_n;
    logic [7:0]  inst_we_addr, data_we_addr;
    logic [4:0]  rf_we_addr;
    logic [31:0] inst_we_data, data_we_data, rf_we_data;

    initial begin
        inst_we_n = 0; data_we_n = 0; rf_we_n = 0; rf_rd_n = 0;
    end

    always @(posedge clk) begin
        if (!rst && link.tx_valid && link.tx_ready) got_q.push_back(link.tx_data);
        if (inst_we) begin
            inst_we_n++; inst_we_addr = inst_addr; inst_we_data = inst_in;
            inst_mem[inst_addr] = inst_in;
        end
        if (data_we) begin
            data_we_n++; data_we_addr = data_addr; data_we_data = data_in;
            data_mem[data_addr] = data_in;
        end
        if (rf_dcp_we) begin
            rf_we_n++; rf_we_addr = rf_addr; rf_we_data = rf_in;
            rf_mem[rf_addr] = rf_in;
        end
        if (rf_dcp_rd) rf_rd_n++;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        link.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        link.rx_data  = b;
        link.rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (link.rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rx_accept_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send(f[i]);
    endtask

    task automatic expect_bytes(input logic [7:0] e[$]);
        foreach (e[i]) exp_q.push_back(e[i]);
    endtask

    // Wait for the frame to finish, then compare everything the DUT sent.
    task automatic drain(input string tag);
        bit done;
        logic [7:0] e;
        done = 1'b0;
        @(negedge clk);
        link.rx_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, {31'h0, done}, 32'h1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) check({tag, "_tx_missing"}, 32'hFFFF_FFFF, 32'(e));
            else                   check({tag, "_tx"}, 32'(got_q.pop_front()), 32'(e));
        end
        check({tag, "_tx_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] first_byte;
    bit         stable;
    int         got_before;
    int         dwe_before;

    initial begin
        rst = 1'b1;
        link.rx_data  = 8'h00;
        link.rx_valid = 1'b0;
        link.tx_ready = 1'b1;
        checks = 0;
        failures = 0;
        do_reset();
        @(negedge clk);

        check("rst_rx_ready",  {31'h0, link.rx_ready}, 32'h1);
        check("rst_tx_valid",  {31'h0, link.tx_valid}, 32'h0);
        check("rst_tx_data",   32'(link.tx_data), 32'h0);
        check("rst_busy",      {31'h0, busy}, 32'h0);
        check("rst_cpu_rstn",  {31'h0, cpu_rstn}, 32'h0);
        check("rst_strobes",   {28'h0, inst_we, data_we, rf_dcp_we, rf_dcp_rd}, 32'h0);
        check("rst_addrs",     {11'h0, inst_addr, data_addr, rf_addr}, 32'h0);
        check("rst_ins",       inst_in | data_in | rf_in, 32'h0);
        check("rst_state",     32'(dbg_state), 32'h0);

        // hold, then instruction write
        send(8'h20); expect_bytes('{8'hA5});
        drain("hold");
        check("hold_cpu_rstn", {31'h0, cpu_rstn}, 32'h0);
        send_frame('{8'h01, 8'h04, 8'h13, 8'h05, 8'h30, 8'h00}); expect_bytes('{8'hA5});
        drain("iwr");
        check("iwr_pulses", inst_we_n, 1);
        check("iwr_addr",   32'(inst_we_addr), 32'h04);
        check("iwr_data",   inst_we_data, 32'h0030_0513);
        check("iwr_hold_addr", 32'(inst_addr), 32'h04);

        // data write then read back
        send_frame('{8'h02, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE}); expect_bytes('{8'hA5});
        send_frame('{8'h12, 8'h10}); expect_bytes('{8'hEF, 8'hBE, 8'hAD, 8'hDE});
        drain("dwr_drd");
        check("dwr_pulses", data_we_n, 1);
        check("dwr_addr",   32'(data_we_addr), 32'h10);
        check("dwr_data",   data_we_data, 32'hDEAD_BEEF);

        // rf write then read back
        send_frame('{8'h03, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12}); expect_bytes('{8'hA5});
        send_frame('{8'h13, 8'h05}); expect_bytes('{8'h78, 8'h56, 8'h34, 8'h12});
        drain("rf");
        check("rf_we_pulses", rf_we_n, 1);
        check("rf_we_addr",   32'(rf_we_addr), 32'h5);
        check("rf_we_data",   rf_we_data, 32'h1234_5678);
        check("rf_rd_cycles", rf_rd_n, 2);

        // release, write refused, unknown opcode, next byte is an OPC
        send(8'h21); expect_bytes('{8'hA5});
        drain("release");
        check("release_cpu_rstn", {31'h0, cpu_rstn}, 32'h1);
        send_frame('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}); expect_bytes('{8'hEB});
        drain("err_run");
        check("err_run_no_we", inst_we_n, 1);
        check("err_run_addr_kept", 32'(inst_addr), 32'h04);
        send(8'h7F); expect_bytes('{8'hEE});
        send(8'h20); expect_bytes('{8'hA5});
        send_frame('{8'h11, 8'h04}); expect_bytes('{8'h13, 8'h05, 8'h30, 8'h00});
        drain("badopc");
        check("badopc_cpu_rstn", {31'h0, cpu_rstn}, 32'h0);

        // back-pressure during a read response
        @(negedge clk);
        link.tx_ready = 1'b0;
        send_frame('{8'h12, 8'h10});
        @(negedge clk);
        link.rx_valid = 1'b0;
        stable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (link.tx_valid) begin
                stable = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stall_tx_valid_seen", {31'h0, stable}, 32'h1);
        first_byte = link.tx_data;
        got_before = got_q.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(link.tx_valid && link.tx_data == first_byte && !link.rx_ready)) stable = 1'b0;
        end
        check("stall_stable", {31'h0, stable}, 32'h1);
        check("stall_first_byte", 32'(first_byte), 32'hEF);
        check("stall_no_bytes", got_q.size() - got_before, 0);
        expect_bytes('{8'hEF, 8'hBE, 8'hAD, 8'hDE});
        link.tx_ready = 1'b1;
        drain("stall");

        // reset in the middle of a write frame
        dwe_before = data_we_n;
        send_frame('{8'h02, 8'h20, 8'h11});
        do_reset();
        repeat (8) @(negedge clk);
        check("midrst_no_we",   data_we_n - dwe_before, 0);
        check("midrst_state",   32'(dbg_state), 32'h0);
        check("midrst_cpu_rstn", {31'h0, cpu_rstn}, 32'h0);
        check("midrst_tx_extra", got_q.size(), 0);
        send(8'h20); expect_bytes('{8'hA5});
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
